// File: rtl/alu_defs.sv
// Shared ALU definitions: opcodes, FSM states and default width.
// Imported by control decode and by the ALU itself.
package alu_defs;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 5;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per clock.
// Keeps the low WIDTH bits of the product.
module alu_mul_seq
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             last;

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign last  = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last) busy_q <= 1'b0;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = last;
  assign product_o = acc_d;

endmodule

// File: rtl/alu_core.sv
// 16-bit ALU stage: single-cycle ops plus a sequential multiply,
// with registered result, zero/carry flags and a done pulse.
module alu_core
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A_bus_in,
  input  logic [WIDTH-1:0] B_bus_in,
  input  logic [3:0]       ALU_op,
  input  logic             ALU_start,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Z_flag,
  output logic             C_flag,
  output logic             ALU_busy,
  output logic             ALU_done
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             done_q, done_d;

  logic             mul_load;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] res;
  logic             cy;
  logic             wr;
  logic [WIDTH:0]   ext;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .load_i    (mul_load),
    .mcand_i   (A_bus_in),
    .mplier_i  (B_bus_in),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Single-cycle datapath; wr=0 means hold result and flags
  always_comb begin
    res = out_q;
    cy  = 1'b0;
    wr  = 1'b1;
    ext = '0;
    unique case (ALU_op)
      OP_ADD: begin
        ext = {1'b0, A_bus_in} + {1'b0, B_bus_in};
        res = ext[WIDTH-1:0];
        cy  = ext[WIDTH];
      end
      OP_SUB: begin
        res = A_bus_in - B_bus_in;
        cy  = A_bus_in < B_bus_in;
      end
      OP_INC: begin
        res = A_bus_in + WIDTH'(1);
        cy  = &A_bus_in;
      end
      OP_DEC: begin
        res = A_bus_in - WIDTH'(1);
        cy  = ~|A_bus_in;
      end
      OP_SHL: begin
        res = A_bus_in << 1;
        cy  = A_bus_in[WIDTH-1];
      end
      OP_SHR: begin
        res = A_bus_in >> 1;
        cy  = A_bus_in[0];
      end
      OP_PASS: res = B_bus_in;
      default: wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    z_d      = z_q;
    c_d      = c_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ALU_start) begin
          if (ALU_op == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            done_d = 1'b1;
            if (wr) begin
              out_d = res;
              z_d   = (res == '0);
              c_d   = cy;
            end
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          out_d   = mul_prod;
          z_d     = (mul_prod == '0);
          c_d     = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign ALU_out  = out_q;
  assign Z_flag   = z_q;
  assign C_flag   = c_q;
  assign ALU_done = done_q;
  assign ALU_busy = (state_q == ST_MUL) && mul_busy;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: vector table for single-cycle ops,
// hand sequences for multiply, ignored starts, reset and back-to-back.
module tb_alu_core;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] A_bus_in = '0;
  logic [15:0] B_bus_in = '0;
  logic [3:0]  ALU_op = '0;
  logic        ALU_start = 1'b0;
  logic [15:0] ALU_out;
  logic        Z_flag;
  logic        C_flag;
  logic        ALU_busy;
  logic        ALU_done;

  int total = 0;
  int bad = 0;

  alu_core dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .A_bus_in  (A_bus_in),
    .B_bus_in  (B_bus_in),
    .ALU_op    (ALU_op),
    .ALU_start (ALU_start),
    .ALU_out   (ALU_out),
    .Z_flag    (Z_flag),
    .C_flag    (C_flag),
    .ALU_busy  (ALU_busy),
    .ALU_done  (ALU_done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic single(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b);
    @(negedge Clock);
    ALU_op = op;
    A_bus_in = a;
    B_bus_in = b;
    ALU_start = 1'b1;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    ALU_start = 1'b0;
  endtask

  task automatic start_mul(input logic [15:0] a, input logic [15:0] b);
    @(negedge Clock);
    ALU_op = 4'd8;
    A_bus_in = a;
    B_bus_in = b;
    ALU_start = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  int busy_cnt;
  int done_cnt;
  int done_edge;

  initial begin
    tbl[0]  = '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[1]  = '{4'd2,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
    tbl[2]  = '{4'd5,  16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b1};
    tbl[3]  = '{4'd6,  16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[4]  = '{4'd7,  16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{4'd3,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[6]  = '{4'd4,  16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
    tbl[7]  = '{4'd2,  16'h0009, 16'h0004, 16'h0005, 1'b0, 1'b0};
    tbl[8]  = '{4'd1,  16'h0040, 16'h0002, 16'h0042, 1'b0, 1'b0};
    tbl[9]  = '{4'd0,  16'hAAAA, 16'h5555, 16'h0042, 1'b0, 1'b0};
    tbl[10] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0042, 1'b0, 1'b0};
    tbl[11] = '{4'd6,  16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0};

    // Reset asserted with no clock edge yet
    #2;
    chk("rst_out", 32'(ALU_out), 32'h0);
    chk("rst_flags", {29'd0, Z_flag, C_flag, ALU_busy}, 32'h0);
    chk("rst_done", 32'(ALU_done), 32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      ALU_op = tbl[i].op;
      A_bus_in = tbl[i].a;
      B_bus_in = tbl[i].b;
      ALU_start = 1'b1;
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_done", i), 32'(ALU_done), 32'h1);
      chk($sformatf("v%0d_out", i), 32'(ALU_out), 32'(tbl[i].out));
      chk($sformatf("v%0d_z", i), 32'(Z_flag), 32'(tbl[i].z));
      chk($sformatf("v%0d_c", i), 32'(C_flag), 32'(tbl[i].c));
      @(negedge Clock);
      ALU_start = 1'b0;
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_done_fall", i), 32'(ALU_done), 32'h0);
    end

    // MUL 0x13*7 with an ignored ADD start and bus toggling mid-flight
    single(4'd7, 16'h0, 16'h5A5A);
    start_mul(16'h0013, 16'h0007);
    chk("mul_start_busy", 32'(ALU_busy), 32'h1);
    chk("mul_start_out", 32'(ALU_out), 32'h5A5A);
    busy_cnt = 0;
    done_edge = 0;
    for (int e = 1; e <= 20 && done_edge == 0; e++) begin
      @(negedge Clock);
      ALU_start = (e == 4);
      ALU_op = (e >= 4) ? 4'd1 : 4'd8;
      A_bus_in = (e % 2 == 0) ? 16'hFFFF : 16'h1111;
      B_bus_in = (e % 2 == 0) ? 16'h0F0F : 16'h2222;
      if (ALU_busy) busy_cnt++;
      @(posedge Clock);
      #1;
      if (ALU_done) done_edge = e;
      else if (e < 16 && ALU_busy !== 1'b1)
        chk($sformatf("mul_busy_e%0d", e), 32'(ALU_busy), 32'h1);
    end
    @(negedge Clock);
    ALU_start = 1'b0;
    chk("mul_done_edge", 32'(done_edge), 32'd16);
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("mul_out", 32'(ALU_out), 32'h0085);
    chk("mul_zc", {30'd0, Z_flag, C_flag}, 32'h0);
    chk("mul_busy_end", 32'(ALU_busy), 32'h0);
    @(posedge Clock);
    #1;
    chk("mul_done_fall", 32'(ALU_done), 32'h0);
    chk("mul_no_add", 32'(ALU_out), 32'h0085);

    // MUL overflow to zero
    start_mul(16'h0100, 16'h0100);
    @(negedge Clock);
    ALU_start = 1'b0;
    done_edge = 0;
    for (int e = 1; e <= 20 && done_edge == 0; e++) begin
      @(posedge Clock);
      #1;
      if (ALU_done) done_edge = e;
    end
    chk("mul2_done_edge", 32'(done_edge), 32'd16);
    chk("mul2_out", 32'(ALU_out), 32'h0000);
    chk("mul2_z", 32'(Z_flag), 32'h1);
    chk("mul2_c", 32'(C_flag), 32'h0);

    // Reset during iteration 8
    single(4'd1, 16'h0040, 16'h0002);
    start_mul(16'h0013, 16'h0007);
    @(negedge Clock);
    ALU_start = 1'b0;
    repeat (8) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("mrst_out", 32'(ALU_out), 32'h0);
    chk("mrst_flags", {29'd0, Z_flag, C_flag, ALU_busy}, 32'h0);
    chk("mrst_done", 32'(ALU_done), 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge Clock);
      #1;
      if (ALU_done || ALU_busy) done_cnt++;
    end
    chk("mrst_no_done", 32'(done_cnt), 32'h0);
    @(negedge Clock);
    ALU_op = 4'd1;
    A_bus_in = 16'h1000;
    B_bus_in = 16'h0234;
    ALU_start = 1'b1;
    @(posedge Clock);
    #1;
    chk("post_rst_add", 32'(ALU_out), 32'h1234);
    chk("post_rst_done", 32'(ALU_done), 32'h1);

    // Three back-to-back starts
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      ALU_op = 4'd3;
      A_bus_in = 16'(k * 16);
      ALU_start = 1'b1;
      @(posedge Clock);
      #1;
      if (ALU_done) done_cnt++;
      chk($sformatf("b2b_out%0d", k), 32'(ALU_out), 32'(k * 16 + 1));
    end
    @(negedge Clock);
    ALU_start = 1'b0;
    chk("b2b_done_cnt", 32'(done_cnt), 32'd3);
    @(posedge Clock);
    #1;
    chk("b2b_done_fall", 32'(ALU_done), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
